// File: rtl/regfile_bank.sv
// Parameterised register file with two combinational read ports, one write port,
// and a sequential clear engine that zeroes every entry one per cycle.
module regfile_bank #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int ZERO_REG0 = 0,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic              state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              wr_commit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Reset counts as busy so reads are forced to zero before the first clear runs.
    assign busy      = rst | (state == CLEAR);
    assign wr_ok     = we & ~busy & ~clr_req;
    assign wr_commit = wr_ok & ~((ZERO_REG0 != 0) && (waddr == '0));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = rst ? '0 : clr_ptr;
            mem_wdata = '0;
        end else if (wr_commit) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= we & ((state == CLEAR) | clr_req);
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_PTR) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Priority: clear/reset masking, then hardwired zero, then same-cycle forwarding.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              busy_i,
        input logic              commit_i,
        input logic [ADDR_W-1:0] waddr_i,
        input logic [DATA_W-1:0] wdata_i
    );
        if (busy_i) begin
            return '0;
        end
        if ((ZERO_REG0 != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && commit_i && (waddr_i == addr)) begin
            return wdata_i;
        end
        return stored;
    endfunction

    assign rdata1 = read_port(raddr1, mem[raddr1], busy, wr_commit, waddr, wdata);
    assign rdata2 = read_port(raddr2, mem[raddr2], busy, wr_commit, waddr, wdata);

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: three instances (defaults, no bypass, zero
// register) share one stimulus stream and are checked against hand-computed values.
module tb_regfile_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_req;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr1;
    logic [2:0] raddr2;

    logic [7:0] rd1_a, rd2_a, rd1_n, rd2_n, rd1_z, rd2_z;
    logic       busy_a, done_a, drop_a;
    logic       busy_n, done_n, drop_n;
    logic       busy_z, done_z, drop_z;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_bank dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
        .busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
    );

    regfile_bank #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .busy(busy_n), .clr_done(done_n), .wr_drop(drop_n)
    );

    regfile_bank #(.ZERO_REG0(1)) dut_z (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_z), .rdata2(rd2_z),
        .busy(busy_z), .clr_done(done_z), .wr_drop(drop_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; raddr1 = 3'd2; raddr2 = 3'd6;

        // Reset held: busy high, outputs quiet.
        tick();
        tick();
        check("rst_busy", {7'd0, busy_a}, 8'd1);
        check("rst_rd1", rd1_a, 8'h00);
        check("rst_rd2", rd2_a, 8'h00);
        check("rst_done", {7'd0, done_a}, 8'd0);
        check("rst_drop", {7'd0, drop_a}, 8'd0);

        // Release: exactly 8 busy cycles, then a single clr_done pulse.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("init_busy_%0d", i), {7'd0, busy_a}, 8'd1);
            check($sformatf("init_done_%0d", i), {7'd0, done_a}, 8'd0);
            tick();
        end
        check("init_idle", {7'd0, busy_a}, 8'd0);
        check("init_done_pulse", {7'd0, done_a}, 8'd1);
        check("init_z_done", {7'd0, done_z}, 8'd1);
        tick();
        check("init_done_end", {7'd0, done_a}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i);
            raddr2 = 3'(7 - i);
            #1;
            check($sformatf("init_rd1_%0d", i), rd1_a, 8'h00);
            check($sformatf("init_rd2_%0d", i), rd2_a, 8'h00);
        end

        // Plain writes, then read back on both ports.
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        tick();
        waddr = 3'd7; wdata = 8'h3C;
        tick();
        we = 1'b0;
        raddr1 = 3'd3; raddr2 = 3'd7;
        #1;
        check("wr_rd1", rd1_a, 8'hA5);
        check("wr_rd2", rd2_a, 8'h3C);
        check("wr_nb_rd2", rd2_n, 8'h3C);
        check("wr_drop_none", {7'd0, drop_a}, 8'd0);
        raddr2 = 3'd3;
        #1;
        check("same_rd1", rd1_a, 8'hA5);
        check("same_rd2", rd2_a, 8'hA5);

        // Same-cycle forwarding versus stored value.
        we = 1'b1; waddr = 3'd5; wdata = 8'h5A; raddr1 = 3'd5;
        #1;
        check("byp_on", rd1_a, 8'h5A);
        check("byp_off", rd1_n, 8'h00);
        check("byp_other_port", rd2_a, 8'hA5);
        tick();
        we = 1'b0;
        #1;
        check("byp_after_on", rd1_a, 8'h5A);
        check("byp_after_off", rd1_n, 8'h5A);

        // Writes to entry 0 are swallowed when it is hardwired.
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr1 = 3'd0;
        #1;
        check("z0_byp", rd1_z, 8'h00);
        check("z0_plain_byp", rd1_a, 8'hFF);
        tick();
        we = 1'b0;
        #1;
        check("z0_rd", rd1_z, 8'h00);
        check("z0_drop", {7'd0, drop_z}, 8'd0);
        check("z0_plain_rd", rd1_a, 8'hFF);

        // Write colliding with a clear request, then a write during the clear.
        clr_req = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'h77; raddr1 = 3'd2;
        #1;
        check("drop_pre_busy", {7'd0, busy_a}, 8'd0);
        tick();
        clr_req = 1'b0; we = 1'b1; waddr = 3'd6; wdata = 8'h99;
        #1;
        check("drop_req", {7'd0, drop_a}, 8'd1);
        check("drop_busy", {7'd0, busy_a}, 8'd1);
        check("drop_busy_rd", rd1_a, 8'h00);
        tick();
        we = 1'b0; clr_req = 1'b1;
        #1;
        check("drop_clear", {7'd0, drop_a}, 8'd1);
        tick();
        clr_req = 1'b0;
        #1;
        check("drop_end", {7'd0, drop_a}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("clr_busy_%0d", i), {7'd0, busy_a}, 8'd1);
            tick();
        end
        check("clr_idle", {7'd0, busy_a}, 8'd0);
        check("clr_done_pulse", {7'd0, done_a}, 8'd1);
        raddr1 = 3'd2; raddr2 = 3'd6;
        #1;
        check("clr_rd2", rd1_a, 8'h00);
        check("clr_rd6", rd2_a, 8'h00);
        raddr1 = 3'd3;
        #1;
        check("clr_rd3", rd1_a, 8'h00);

        // Reset arriving mid-clear restarts the sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        rst = 1'b1;
        #1;
        check("mid_rst_rd", rd1_a, 8'h00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("mid_busy_%0d", i), {7'd0, busy_a}, 8'd1);
            check($sformatf("mid_done_%0d", i), {7'd0, done_a}, 8'd0);
            tick();
        end
        check("mid_idle", {7'd0, busy_a}, 8'd0);
        check("mid_done_pulse", {7'd0, done_a}, 8'd1);
        check("mid_n_done", {7'd0, done_n}, 8'd1);
        tick();
        check("mid_done_end", {7'd0, done_a}, 8'd0);

        // Normal operation resumes.
        we = 1'b1; waddr = 3'd4; wdata = 8'h42;
        tick();
        we = 1'b0; raddr1 = 3'd4; raddr2 = 3'd4;
        #1;
        check("post_rd1", rd1_a, 8'h42);
        check("post_z_rd2", rd2_z, 8'h42);
        check("post_n_busy", {7'd0, busy_n}, 8'd0);
        check("post_z_busy", {7'd0, busy_z}, 8'd0);
        check("post_n_drop", {7'd0, drop_n}, 8'd0);
        check("post_n_rd1", rd1_n, 8'h42);
        check("post_z_rd1", rd1_z, 8'h42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
